// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
// Consumer side of the stage-2 hazard interface. Turns single-cycle stall and
// flush requests into timed multi-cycle freeze/flush sequences for the
// pipeline register controls.
//
// Parameters:
//   STALL_CYCLES  cycles the front end is frozen per stall request (1..15)
//   FLUSH_CYCLES  cycles IF/ID flush + ID/EX bubble last per flush (1..15)
//
// Ports:
//   clk          in   pipeline clock, rising edge
//   rst_n        in   synchronous active-low reset
//   stall_req    in   stage-2 hazard stall request (single-cycle trigger)
//   hold_req     in   level hold of the front end
//   flush_req    in   stage-4 taken-branch flush request
//   pc_we        out  PC write enable
//   ifid_we      out  IF/ID write enable
//   ifid_flush   out  clear IF/ID to NOP
//   idex_bubble  out  load NOP controls into ID/EX
//   exmem_flush  out  squash instruction entering EX/MEM
//   busy         out  pc_we low or any flush output high
//   state        out  FSM state (00 RUN, 01 STALL, 10 FLUSH)
//   stall_cycles out  saturating count of frozen cycles
//
// Optional feature macro: STALL_STATS_EN enables the stall_cycles counter;
// without it stall_cycles is tied to zero.

module pipe_stall_ctrl #(
    parameter int STALL_CYCLES = 2,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_req,
    input  logic        hold_req,
    input  logic        flush_req,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        exmem_flush,
    output logic        busy,
    output logic [1:0]  state,
    output logic [15:0] stall_cycles
);

    generate
        if (STALL_CYCLES < 1 || STALL_CYCLES > 15) begin : g_bad_stall
            $fatal(1, "pipe_stall_ctrl: STALL_CYCLES out of range 1..15");
        end
        if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush
            $fatal(1, "pipe_stall_ctrl: FLUSH_CYCLES out of range 1..15");
        end
    endgenerate

    // The request cycle itself counts as the first cycle, so the counter is
    // loaded with N-2 and the sequence ends when it reads zero.
    localparam logic [3:0] STALL_LOAD = (STALL_CYCLES > 1) ? 4'(STALL_CYCLES - 2) : 4'd0;
    localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_STALL   = 2'b01,
        ST_FLUSH   = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_cnt;
    logic [3:0] w_next_cnt;

    logic w_pc_we;
    logic w_ifid_we;
    logic w_ifid_flush;
    logic w_idex_bubble;
    logic w_exmem_flush;
    logic w_flush_start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_pc_we       = 1'b1;
        w_ifid_we     = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_exmem_flush = 1'b0;
        w_flush_start = 1'b0;

        if (rst_n) begin
            case (r_state)
                ST_RUN: begin
                    if (flush_req) begin
                        w_flush_start = 1'b1;
                    end else if (stall_req) begin
                        w_pc_we       = 1'b0;
                        w_ifid_we     = 1'b0;
                        w_idex_bubble = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            w_next_state = ST_STALL;
                            w_next_cnt   = STALL_LOAD;
                        end
                    end else if (hold_req) begin
                        w_pc_we       = 1'b0;
                        w_ifid_we     = 1'b0;
                        w_idex_bubble = 1'b1;
                    end
                end
                ST_STALL: begin
                    if (flush_req) begin
                        w_flush_start = 1'b1;
                    end else begin
                        w_pc_we       = 1'b0;
                        w_ifid_we     = 1'b0;
                        w_idex_bubble = 1'b1;
                        if (r_cnt == 4'd0) begin
                            w_next_state = ST_RUN;
                        end else begin
                            w_next_cnt = r_cnt - 4'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    w_ifid_flush  = 1'b1;
                    w_idex_bubble = 1'b1;
                    if (flush_req) begin
                        w_flush_start = 1'b1;
                    end else if (r_cnt == 4'd0) begin
                        w_next_state = ST_RUN;
                    end else begin
                        w_next_cnt = r_cnt - 4'd1;
                    end
                end
                default: begin
                    w_next_state = ST_RUN;
                    w_next_cnt   = '0;
                end
            endcase

            // A flush from any state: same outputs and the same transition,
            // which also covers restarting a flush already in progress.
            if (w_flush_start) begin
                w_pc_we       = 1'b1;
                w_ifid_we     = 1'b1;
                w_ifid_flush  = 1'b1;
                w_idex_bubble = 1'b1;
                w_exmem_flush = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    w_next_state = ST_FLUSH;
                    w_next_cnt   = FLUSH_LOAD;
                end else begin
                    w_next_state = ST_RUN;
                    w_next_cnt   = '0;
                end
            end
        end
    end

    assign pc_we       = w_pc_we;
    assign ifid_we     = w_ifid_we;
    assign ifid_flush  = w_ifid_flush;
    assign idex_bubble = w_idex_bubble;
    assign exmem_flush = w_exmem_flush;
    assign busy        = !w_pc_we || w_ifid_flush || w_exmem_flush;
    assign state       = r_state;

`ifdef STALL_STATS_EN
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (!w_pc_we && r_stall_cycles != '1) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl
// Table-driven bench for pipe_stall_ctrl. Two instances share the inputs:
// A with STALL_CYCLES=2/FLUSH_CYCLES=1 and B with STALL_CYCLES=3/FLUSH_CYCLES=3.
// Each table row is one clock cycle: inputs for that cycle and the expected
// Mealy outputs {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush, busy,
// state[1:0]} observed during it. The stall statistics expectation is derived
// from the expected pc_we column of the table.

module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic stall_req;
    logic hold_req;
    logic flush_req;

    logic        a_pc_we, a_ifid_we, a_ifid_flush, a_idex_bubble, a_exmem_flush, a_busy;
    logic [1:0]  a_state;
    logic [15:0] a_stall_cycles;
    logic        b_pc_we, b_ifid_we, b_ifid_flush, b_idex_bubble, b_exmem_flush, b_busy;
    logic [1:0]  b_state;
    logic [15:0] b_stall_cycles;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.STALL_CYCLES(2), .FLUSH_CYCLES(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .hold_req(hold_req),
        .flush_req(flush_req), .pc_we(a_pc_we), .ifid_we(a_ifid_we),
        .ifid_flush(a_ifid_flush), .idex_bubble(a_idex_bubble),
        .exmem_flush(a_exmem_flush), .busy(a_busy), .state(a_state),
        .stall_cycles(a_stall_cycles)
    );

    pipe_stall_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .hold_req(hold_req),
        .flush_req(flush_req), .pc_we(b_pc_we), .ifid_we(b_ifid_we),
        .ifid_flush(b_ifid_flush), .idex_bubble(b_idex_bubble),
        .exmem_flush(b_exmem_flush), .busy(b_busy), .state(b_state),
        .stall_cycles(b_stall_cycles)
    );

    logic [7:0] act_a;
    logic [7:0] act_b;
    assign act_a = {a_pc_we, a_ifid_we, a_ifid_flush, a_idex_bubble, a_exmem_flush, a_busy, a_state};
    assign act_b = {b_pc_we, b_ifid_we, b_ifid_flush, b_idex_bubble, b_exmem_flush, b_busy, b_state};

    // Expected output patterns (pc ifwe iff bub exf busy st[1:0])
    localparam logic [7:0] O_RUN   = 8'b1100_0000; // RUN, no request
    localparam logic [7:0] O_STL_R = 8'b0001_0100; // stall/hold outputs in RUN
    localparam logic [7:0] O_STL_S = 8'b0001_0101; // STALL state
    localparam logic [7:0] O_FL_R  = 8'b1111_1100; // flush raised in RUN
    localparam logic [7:0] O_FL_S  = 8'b1111_1101; // flush raised in STALL
    localparam logic [7:0] O_FL_F  = 8'b1111_0110; // FLUSH state, no new flush
    localparam logic [7:0] O_FL_FR = 8'b1111_1110; // flush restart in FLUSH

    typedef struct {
        string      name;
        bit         dut;   // 0 = A, 1 = B
        bit         rst_n;
        bit         stall;
        bit         hold;
        bit         flush;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    int checks = 0;
    int errors = 0;

    function automatic void add(string n, bit d, bit r, bit s, bit h, bit f, logic [7:0] e);
        vec_t v;
        v.name = n; v.dut = d; v.rst_n = r; v.stall = s; v.hold = h; v.flush = f; v.exp = e;
        tbl.push_back(v);
    endfunction

    initial begin
        vec_t        v;
        logic [7:0]  act;
        logic [15:0] act_stats;
        logic [15:0] m_stats;
        bit          m_valid;
        bit          cur_dut;

        rst_n = 1'b0; stall_req = 1'b0; hold_req = 1'b0; flush_req = 1'b0;

        // ---- instance A: STALL_CYCLES=2, FLUSH_CYCLES=1 ----
        add("rst_req_ignored0", 0, 0, 1, 0, 1, O_RUN);
        add("rst_req_ignored1", 0, 0, 1, 0, 1, O_RUN);
        add("rst_hold_ignored", 0, 0, 0, 1, 0, O_RUN);
        add("run_idle",         0, 1, 0, 0, 0, O_RUN);
        add("stall_T",          0, 1, 1, 0, 0, O_STL_R);
        add("stall_T1",         0, 1, 0, 0, 0, O_STL_S);
        add("stall_T2_release", 0, 1, 0, 0, 0, O_RUN);
        add("held_T",           0, 1, 1, 0, 0, O_STL_R);
        add("held_T1",          0, 1, 1, 0, 0, O_STL_S);
        add("held_T2",          0, 1, 1, 0, 0, O_STL_R);
        add("held_T3",          0, 1, 1, 0, 0, O_STL_S);
        add("held_T4",          0, 1, 1, 0, 0, O_STL_R);
        add("held_T5",          0, 1, 0, 0, 0, O_STL_S);
        add("held_T6_release",  0, 1, 0, 0, 0, O_RUN);
        add("abort_stall_T",    0, 1, 1, 0, 0, O_STL_R);
        add("abort_flush_T1",   0, 1, 0, 0, 1, O_FL_S);
        add("abort_run_T2",     0, 1, 0, 0, 0, O_RUN);
        add("simul_all_req",    0, 1, 1, 1, 1, O_FL_R);
        add("simul_after",      0, 1, 0, 0, 0, O_RUN);
        add("hold_c0",          0, 1, 0, 1, 0, O_STL_R);
        add("hold_c1",          0, 1, 0, 1, 0, O_STL_R);
        add("hold_c2",          0, 1, 0, 1, 0, O_STL_R);
        add("hold_c3",          0, 1, 0, 1, 0, O_STL_R);
        add("hold_dropped",     0, 1, 0, 0, 0, O_RUN);
        add("stall_then_hold",  0, 1, 1, 0, 0, O_STL_R);
        add("hold_in_stall",    0, 1, 0, 1, 0, O_STL_S);
        add("hold_back_in_run", 0, 1, 0, 1, 0, O_STL_R);
        add("hold_end",         0, 1, 0, 0, 0, O_RUN);
        add("stall_before_rst", 0, 1, 1, 0, 0, O_STL_R);
        add("rst_in_stall",     0, 0, 0, 0, 0, 8'b1100_0001);
        add("run_after_rst",    0, 1, 0, 0, 0, O_RUN);

        // ---- instance B: STALL_CYCLES=3, FLUSH_CYCLES=3 ----
        add("b_rst",            1, 0, 0, 0, 0, O_RUN);
        add("b_idle",           1, 1, 0, 0, 0, O_RUN);
        add("b_simul_c0",       1, 1, 1, 1, 1, O_FL_R);
        add("b_simul_c1",       1, 1, 1, 1, 0, O_FL_F);
        add("b_simul_c2",       1, 1, 0, 0, 0, O_FL_F);
        add("b_simul_done",     1, 1, 0, 0, 0, O_RUN);
        add("b_stall_c0",       1, 1, 1, 0, 0, O_STL_R);
        add("b_stall_c1",       1, 1, 0, 0, 0, O_STL_S);
        add("b_stall_c2",       1, 1, 0, 0, 0, O_STL_S);
        add("b_stall_done",     1, 1, 0, 0, 0, O_RUN);
        add("b_flush_c0",       1, 1, 0, 0, 1, O_FL_R);
        add("b_flush_restart",  1, 1, 0, 0, 1, O_FL_FR);
        add("b_restart_c1",     1, 1, 0, 0, 0, O_FL_F);
        add("b_restart_c2",     1, 1, 0, 0, 0, O_FL_F);
        add("b_restart_done",   1, 1, 0, 0, 0, O_RUN);
        add("b_abort_stall",    1, 1, 1, 0, 0, O_STL_R);
        add("b_abort_flush",    1, 1, 0, 0, 1, O_FL_S);
        add("b_abort_c1",       1, 1, 0, 0, 0, O_FL_F);
        add("b_abort_c2",       1, 1, 0, 0, 0, O_FL_F);
        add("b_abort_done",     1, 1, 0, 0, 0, O_RUN);
        add("b_flush_pre_rst",  1, 1, 0, 0, 1, O_FL_R);
        add("b_rst_in_flush",   1, 0, 0, 0, 0, 8'b1100_0010);
        add("b_run_after_rst",  1, 1, 0, 0, 0, O_RUN);

        // Two reset edges before the table so instance A starts from a known state.
        repeat (2) @(posedge clk);
        m_stats = '0;
        m_valid = 1'b1;
        cur_dut = 1'b0;

        for (int unsigned i = 0; i < $unsigned(tbl.size()); i++) begin
            @(posedge clk);
            #1;
            rst_n     = tbl[i].rst_n;
            stall_req = tbl[i].stall;
            hold_req  = tbl[i].hold;
            flush_req = tbl[i].flush;
            sb.push_back(tbl[i]);

            @(negedge clk);
            v = sb.pop_front();
            act       = v.dut ? act_b : act_a;
            act_stats = v.dut ? b_stall_cycles : a_stall_cycles;

            checks++;
            if (act !== v.exp) begin
                errors++;
                $display("FAIL %s (row %0d): outputs got %b expected %b", v.name, i, act, v.exp);
            end

            // Statistics expectation is only known once this instance has
            // seen a reset edge while being tracked.
            if (v.dut != cur_dut) begin
                cur_dut = v.dut;
                m_valid = 1'b0;
            end
            if (m_valid) begin
                checks++;
`ifdef STALL_STATS_EN
                if (act_stats !== m_stats) begin
                    errors++;
                    $display("FAIL %s_stats (row %0d): stall_cycles got %0d expected %0d", v.name, i, act_stats, m_stats);
                end
`else
                if (act_stats !== 16'h0000) begin
                    errors++;
                    $display("FAIL %s_stats (row %0d): stall_cycles got %0d expected 0", v.name, i, act_stats);
                end
`endif
            end
            if (!v.rst_n) begin
                m_stats = '0;
                m_valid = 1'b1;
            end else if (!v.exp[7] && m_stats != 16'hFFFF) begin
                m_stats = m_stats + 16'd1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
